wb_stage: RTL and testbench

Registered writeback stage for the pipelined RV core, replacing the combinational writeback select. It captures the retiring MEM-stage instruction and selects PC+4, ALU result or load data. It extracts and sign/zero-extends sub-word loads and waits for variable-latency load data, stalling upstream while it waits. A load timeout flags a lost memory response.

---
 rtl/wb_stage.sv | 148 ++++++++++++++
 tb/tb_wb_stage.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Registered writeback stage: selects PC+4 / ALU / load data, extracts
// sub-word loads and stalls upstream while waiting on load data.
module wb_stage #(
  parameter int XLEN       = 32,
  parameter int LD_TIMEOUT = 16,
  parameter int OFFW       = $clog2(XLEN/8)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mem_valid_i,
  input  logic [1:0]      mem_wb_sel_i,
  input  logic [4:0]      mem_rd_addr_i,
  input  logic            mem_rd_wren_i,
  input  logic [XLEN-1:0] mem_alu_data_i,
  input  logic [XLEN-1:0] mem_pc_four_i,
  input  logic [1:0]      mem_ld_size_i,
  input  logic            mem_ld_unsigned_i,
  input  logic [OFFW-1:0] mem_addr_lo_i,
  input  logic            ld_valid_i,
  input  logic [XLEN-1:0] ld_data_i,
  output logic            stall_o,
  output logic            wb_valid_o,
  output logic            rd_wren_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            ld_err_o
);

  typedef enum logic {IDLE, WAIT_LD} state_t;

  localparam logic [15:0] TLAST = 16'(LD_TIMEOUT - 1);

  state_t          state;
  logic [15:0]     cnt;
  logic [4:0]      lat_addr;
  logic            lat_wren;
  logic [1:0]      lat_size;
  logic            lat_uns;
  logic [OFFW-1:0] lat_off;
  logic [XLEN-1:0] sel_data;
  logic            sel_wren;
  logic            is_load;

  function automatic logic [XLEN-1:0] extract(
    input logic [XLEN-1:0] d,
    input logic [1:0]      sz,
    input logic            uns,
    input logic [OFFW-1:0] off
  );
    logic [OFFW-1:0] o;
    logic [XLEN-1:0] sh;
    int              w;
    o = off;
    w = XLEN;
    unique case (sz)
      2'b00: w = 8;
      2'b01: begin
        w    = 16;
        o[0] = 1'b0;
      end
      2'b10: begin
        w      = 32;
        o[1:0] = '0;
      end
      default: o = '0;
    endcase
    // Left-justify the lane, then shift back to extend.
    sh = (d >> {o, 3'b000}) << (XLEN - w);
    if (uns) return sh >> (XLEN - w);
    return XLEN'($signed(sh) >>> (XLEN - w));
  endfunction

  assign is_load = mem_wb_sel_i == 2'b10;

  always_comb begin
    sel_data = '0;
    sel_wren = mem_rd_wren_i && (mem_rd_addr_i != 5'd0);
    unique case (mem_wb_sel_i)
      2'b00: sel_data = mem_pc_four_i;
      2'b01: sel_data = mem_alu_data_i;
      2'b10: sel_data = extract(ld_data_i, mem_ld_size_i,
                                mem_ld_unsigned_i, mem_addr_lo_i);
      default: sel_wren = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_wren   <= 1'b0;
      lat_size   <= '0;
      lat_uns    <= 1'b0;
      lat_off    <= '0;
      stall_o    <= 1'b0;
      wb_valid_o <= 1'b0;
      rd_wren_o  <= 1'b0;
      rd_addr_o  <= '0;
      rd_data_o  <= '0;
      ld_err_o   <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      rd_wren_o  <= 1'b0;
      ld_err_o   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_valid_i) begin
            if (is_load && !ld_valid_i) begin
              lat_addr <= mem_rd_addr_i;
              lat_wren <= mem_rd_wren_i;
              lat_size <= mem_ld_size_i;
              lat_uns  <= mem_ld_unsigned_i;
              lat_off  <= mem_addr_lo_i;
              cnt      <= '0;
              stall_o  <= 1'b1;
              state    <= WAIT_LD;
            end else begin
              wb_valid_o <= 1'b1;
              rd_wren_o  <= sel_wren;
              rd_addr_o  <= mem_rd_addr_i;
              rd_data_o  <= sel_data;
            end
          end
        end
        WAIT_LD: begin
          if (ld_valid_i) begin
            wb_valid_o <= 1'b1;
            rd_wren_o  <= lat_wren && (lat_addr != 5'd0);
            rd_addr_o  <= lat_addr;
            rd_data_o  <= extract(ld_data_i, lat_size, lat_uns, lat_off);
            stall_o    <= 1'b0;
            state      <= IDLE;
          end else if (LD_TIMEOUT != 0 && cnt == TLAST) begin
            wb_valid_o <= 1'b1;
            rd_data_o  <= '0;
            ld_err_o   <= 1'b1;
            stall_o    <= 1'b0;
            state      <= IDLE;
          end else if (LD_TIMEOUT != 0) begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage (XLEN=32, LD_TIMEOUT=4) with
// directed scenarios and a randomized run against a reference model.
module tb_wb_stage;

  localparam int XLEN = 32;
  localparam int TMO  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [1:0]  mem_wb_sel;
  logic [4:0]  mem_rd_addr;
  logic        mem_rd_wren;
  logic [31:0] mem_alu_data;
  logic [31:0] mem_pc_four;
  logic [1:0]  mem_ld_size;
  logic        mem_ld_unsigned;
  logic [1:0]  mem_addr_lo;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        stall;
  logic        wb_valid;
  logic        rd_wren;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        ld_err;

  int asserts = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(XLEN), .LD_TIMEOUT(TMO)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .mem_valid_i(mem_valid),
    .mem_wb_sel_i(mem_wb_sel),
    .mem_rd_addr_i(mem_rd_addr),
    .mem_rd_wren_i(mem_rd_wren),
    .mem_alu_data_i(mem_alu_data),
    .mem_pc_four_i(mem_pc_four),
    .mem_ld_size_i(mem_ld_size),
    .mem_ld_unsigned_i(mem_ld_unsigned),
    .mem_addr_lo_i(mem_addr_lo),
    .ld_valid_i(ld_valid),
    .ld_data_i(ld_data),
    .stall_o(stall),
    .wb_valid_o(wb_valid),
    .rd_wren_o(rd_wren),
    .rd_addr_o(rd_addr),
    .rd_data_o(rd_data),
    .ld_err_o(ld_err)
  );

  // Reference load extraction by byte arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] d,
      input logic [1:0] sz, input logic uns, input logic [1:0] off);
    int     nb;
    int     lane;
    longint v;
    longint span;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lane = int'(off) - (int'(off) % nb);
    span = longint'(1) << (8 * nb);
    v    = (longint'(d) >> (8 * lane)) % span;
    if (!uns && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [1:0] sel, input logic [4:0] rd,
      input logic wren, input logic [31:0] alu, input logic [31:0] pc4,
      input logic [1:0] sz, input logic uns, input logic [1:0] off);
    mem_valid       = 1'b1;
    mem_wb_sel      = sel;
    mem_rd_addr     = rd;
    mem_rd_wren     = wren;
    mem_alu_data    = alu;
    mem_pc_four     = pc4;
    mem_ld_size     = sz;
    mem_ld_unsigned = uns;
    mem_addr_lo     = off;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mem_valid = 1'b0;
    ld_valid = 1'b0;
    ld_data = '0;
    present(2'd0, 5'd0, 1'b0, '0, '0, 2'd0, 1'b0, 2'd0);
    mem_valid = 1'b0;
    tick();
    tick();
    asserts++;
    if ({stall, wb_valid, rd_wren, rd_addr, rd_data, ld_err} !== 40'd0) begin
      fails++;
      $display("FAIL reset: outputs %h required 0",
               {stall, wb_valid, rd_wren, rd_addr, rd_data, ld_err});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu;
    present(2'b01, 5'd5, 1'b1, 32'h1234_5678, 32'h0, 2'd0, 1'b0, 2'd0);
    tick();
    mem_valid = 1'b0;
    asserts++;
    if ({wb_valid, rd_wren, rd_addr, rd_data, stall} !==
        {1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b0}) begin
      fails++;
      $display("FAIL alu: v=%b we=%b a=%0d d=%h st=%b required 1 1 5 12345678 0",
               wb_valid, rd_wren, rd_addr, rd_data, stall);
    end
    tick();
    asserts++;
    if ({wb_valid, rd_wren, rd_addr, rd_data} !== {2'b00, 5'd5, 32'h1234_5678}) begin
      fails++;
      $display("FAIL alu_idle: v=%b we=%b a=%0d d=%h required 0 0 5 12345678",
               wb_valid, rd_wren, rd_addr, rd_data);
    end
  endtask

  task automatic test_jal_x0;
    present(2'b00, 5'd0, 1'b1, 32'hDEAD, 32'h104, 2'd0, 1'b0, 2'd0);
    tick();
    mem_valid = 1'b0;
    asserts++;
    if ({wb_valid, rd_wren, rd_data} !== {2'b10, 32'h104}) begin
      fails++;
      $display("FAIL jal_x0: v=%b we=%b d=%h required 1 0 00000104",
               wb_valid, rd_wren, rd_data);
    end
  endtask

  task automatic test_load_byte;
    present(2'b10, 5'd6, 1'b1, '0, '0, 2'd0, 1'b0, 2'd2);
    ld_valid = 1'b1;
    ld_data  = 32'h0080_0000;
    tick();
    asserts++;
    if ({wb_valid, rd_wren, rd_data, stall} !== {2'b11, 32'hFFFF_FF80, 1'b0}) begin
      fails++;
      $display("FAIL lb_signed: v=%b we=%b d=%h st=%b required 1 1 ffffff80 0",
               wb_valid, rd_wren, rd_data, stall);
    end
    mem_ld_unsigned = 1'b1;
    tick();
    mem_valid = 1'b0;
    ld_valid  = 1'b0;
    asserts++;
    if ({wb_valid, rd_data} !== {1'b1, 32'h0000_0080}) begin
      fails++;
      $display("FAIL lb_unsigned: v=%b d=%h required 1 00000080", wb_valid, rd_data);
    end
  endtask

  task automatic test_load_wait;
    present(2'b10, 5'd3, 1'b1, '0, '0, 2'd1, 1'b0, 2'd2);
    tick();
    present(2'b01, 5'd7, 1'b1, 32'h0000_AAAA, '0, 2'd0, 1'b0, 2'd0);
    for (int k = 1; k <= 3; k++) begin
      asserts++;
      if ({stall, wb_valid} !== 2'b10) begin
        fails++;
        $display("FAIL lh_wait_stall N+%0d: st=%b v=%b required 1 0", k, stall, wb_valid);
      end
      if (k == 3) begin
        ld_valid = 1'b1;
        ld_data  = 32'h8001_0000;
      end
      tick();
    end
    ld_valid = 1'b0;
    ld_data  = 32'h0;
    asserts++;
    if ({stall, wb_valid, rd_wren, rd_addr, rd_data} !==
        {3'b011, 5'd3, 32'hFFFF_8001}) begin
      fails++;
      $display("FAIL lh_wait_data: st=%b v=%b we=%b a=%0d d=%h required 0 1 1 3 ffff8001",
               stall, wb_valid, rd_wren, rd_addr, rd_data);
    end
    tick();
    mem_valid = 1'b0;
    asserts++;
    if ({wb_valid, rd_wren, rd_addr, rd_data} !== {2'b11, 5'd7, 32'h0000_AAAA}) begin
      fails++;
      $display("FAIL held_alu: v=%b we=%b a=%0d d=%h required 1 1 7 0000aaaa",
               wb_valid, rd_wren, rd_addr, rd_data);
    end
  endtask

  task automatic test_timeout;
    present(2'b10, 5'd9, 1'b1, '0, '0, 2'd2, 1'b0, 2'd0);
    tick();
    mem_valid = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      asserts++;
      if ({stall, ld_err} !== 2'b10) begin
        fails++;
        $display("FAIL timeout_stall N+%0d: st=%b err=%b required 1 0", k, stall, ld_err);
      end
      tick();
    end
    asserts++;
    if ({ld_err, wb_valid, rd_wren, stall, rd_data} !== {4'b1100, 32'h0}) begin
      fails++;
      $display("FAIL timeout_err: err=%b v=%b we=%b st=%b d=%h required 1 1 0 0 0",
               ld_err, wb_valid, rd_wren, stall, rd_data);
    end
    tick();
    asserts++;
    if ({ld_err, wb_valid} !== 2'b00) begin
      fails++;
      $display("FAIL timeout_after: err=%b v=%b required 0 0", ld_err, wb_valid);
    end
  endtask

  task automatic test_reset_in_wait;
    present(2'b10, 5'd12, 1'b1, '0, '0, 2'd2, 1'b0, 2'd0);
    tick();
    mem_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    asserts++;
    if ({stall, wb_valid, rd_wren, rd_addr, rd_data, ld_err} !== 40'd0) begin
      fails++;
      $display("FAIL reset_in_wait: outputs %h required 0",
               {stall, wb_valid, rd_wren, rd_addr, rd_data, ld_err});
    end
    ld_valid = 1'b1;
    ld_data  = 32'hCAFE_F00D;
    tick();
    ld_valid = 1'b0;
    asserts++;
    if ({wb_valid, rd_wren, stall} !== 3'b000) begin
      fails++;
      $display("FAIL stale_ld: v=%b we=%b st=%b required 0 0 0", wb_valid, rd_wren, stall);
    end
  endtask

  task automatic test_random;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        wren;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [1:0]  sz;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] dat;
    logic [31:0] exp_d;
    logic        exp_we;
    int          lat;
    for (int i = 0; i < 300; i++) begin
      sel  = 2'($urandom_range(0, 3));
      rd   = 5'($urandom);
      wren = 1'($urandom);
      alu  = $urandom;
      pc4  = $urandom;
      sz   = 2'($urandom);
      uns  = 1'($urandom);
      off  = 2'($urandom);
      dat  = $urandom;
      lat  = (sel == 2'b10) ? $urandom_range(0, TMO - 1) : 0;
      exp_we = wren && rd != 5'd0 && sel != 2'b11;
      exp_d  = (sel == 2'b00) ? pc4 : (sel == 2'b01) ? alu :
               (sel == 2'b10) ? ref_load(dat, sz, uns, off) : 32'h0;
      present(sel, rd, wren, alu, pc4, sz, uns, off);
      ld_valid = (lat == 0) && (sel == 2'b10);
      ld_data  = (lat == 0) ? dat : $urandom;
      tick();
      mem_valid = 1'b0;
      ld_valid  = 1'b0;
      for (int k = 1; k <= lat; k++) begin
        asserts++;
        if (stall !== 1'b1) begin
          fails++;
          $display("FAIL rnd_stall #%0d cyc %0d: st=%b required 1", i, k, stall);
        end
        if (k == lat) begin
          ld_valid = 1'b1;
          ld_data  = dat;
        end
        tick();
        ld_valid = 1'b0;
      end
      asserts++;
      if ({wb_valid, rd_wren, rd_addr, rd_data, stall, ld_err} !==
          {1'b1, exp_we, rd, exp_d, 2'b00}) begin
        fails++;
        $display("FAIL rnd_retire #%0d sel=%0d sz=%0d u=%b off=%0d: v=%b we=%b a=%0d d=%h st=%b err=%b required 1 %b %0d %h 0 0",
                 i, sel, sz, uns, off, wb_valid, rd_wren, rd_addr, rd_data,
                 stall, ld_err, exp_we, rd, exp_d);
      end
      if ($urandom_range(0, 3) == 0) tick();
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_jal_x0();
    test_load_byte();
    test_load_wait();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
